// File: rtl/wt_cache_pkg.sv
// Request/return payloads shared by the write-through I$/D$ and their memory-side adapters.
package wt_cache_pkg;

    localparam int unsigned ICACHE_LINE_WIDTH = 128;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        ICACHE_IFILL_REQ = 2'd0,
        ICACHE_NC_REQ    = 2'd1
    } icache_out_t;

    typedef enum logic [1:0] {
        ICACHE_INV_REQ   = 2'd0,
        ICACHE_IFILL_ACK = 2'd1
    } icache_in_t;

    typedef enum logic [1:0] {
        DCACHE_LOAD_REQ   = 2'd0,
        DCACHE_STORE_REQ  = 2'd1,
        DCACHE_ATOMIC_REQ = 2'd2
    } dcache_out_t;

    typedef enum logic [1:0] {
        DCACHE_INV_REQ    = 2'd0,
        DCACHE_LOAD_ACK   = 2'd1,
        DCACHE_STORE_ACK  = 2'd2,
        DCACHE_ATOMIC_ACK = 2'd3
    } dcache_in_t;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5
    } amo_t;

    typedef struct packed {
        logic        vld;
        logic        all;
        logic [11:0] idx;
        logic [1:0]  way;
    } cache_inval_t;

    typedef struct packed {
        icache_out_t rtype;
        logic        nc;
        logic [1:0]  way;
        logic [63:0] paddr;
        logic [1:0]  tid;
    } icache_req_t;

    typedef struct packed {
        icache_in_t                   rtype;
        logic [ICACHE_LINE_WIDTH-1:0] data;
        cache_inval_t                 inv;
        logic [1:0]                   tid;
    } icache_rtrn_t;

    typedef struct packed {
        dcache_out_t rtype;
        logic [2:0]  size;
        logic [1:0]  way;
        logic [63:0] paddr;
        logic [63:0] data;
        logic        nc;
        logic [2:0]  tid;
        amo_t        amo_op;
    } dcache_req_t;

    typedef struct packed {
        dcache_in_t                   rtype;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        cache_inval_t                 inv;
        logic [2:0]                   tid;
    } dcache_rtrn_t;

endpackage

// File: rtl/wt_mem_responder.sv
// Standalone memory responder for the write-through I$/D$: arbitrates, serves from a word array, returns in order.
// Optional WT_MEM_RSP_RANDOM_LAT_EN adds 0-3 cycles of LFSR jitter to each return.
module wt_mem_responder
    import wt_cache_pkg::*;
#(
    parameter int unsigned AddrBits = 12,
    parameter int unsigned Latency  = 4,
    parameter int unsigned Depth    = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         icache_data_req_i,
    output logic         icache_data_ack_o,
    input  icache_req_t  icache_data_i,
    output logic         icache_rtrn_vld_o,
    output icache_rtrn_t icache_rtrn_o,
    input  logic         dcache_data_req_i,
    output logic         dcache_data_ack_o,
    input  dcache_req_t  dcache_data_i,
    output logic         dcache_rtrn_vld_o,
    output dcache_rtrn_t dcache_rtrn_o,
    output logic         busy_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CntW   = $clog2(Latency + 4);
    localparam int unsigned IWords = ICACHE_LINE_WIDTH / 64;
    localparam int unsigned DWords = DCACHE_LINE_WIDTH / 64;

    typedef struct packed {
        logic            side;
        icache_rtrn_t    irtrn;
        dcache_rtrn_t    drtrn;
        logic [CntW-1:0] cnt;
    } entry_t;

    logic [63:0]     mem_q [2**AddrBits];
    entry_t          fifo_q [Depth];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic            rr_q;
    logic            full, empty, push, pop, contested;
    logic            grant_i, grant_d;
    entry_t          head, new_e;
    logic [AddrBits-1:0] i_idx, d_idx, i_base, d_base;
    logic [63:0]     d_word, st_word, amo_word, mem_wdata;
    logic [7:0]      lanes, be;
    logic            mem_we;
    logic [CntW-1:0] load_cnt;
    logic            unused_bits;

    assign unused_bits = ^{icache_data_i.rtype, icache_data_i.nc, icache_data_i.way,
                           icache_data_i.paddr[63:AddrBits+3], icache_data_i.paddr[2:0],
                           dcache_data_i.way, dcache_data_i.paddr[63:AddrBits+3],
                           dcache_data_i.size[2]};

    // Occupancy, round-robin arbitration and pop decision
    assign full      = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign grant_i   = icache_data_req_i && !full && (!dcache_data_req_i || !rr_q);
    assign grant_d   = dcache_data_req_i && !full && (!icache_data_req_i || rr_q);
    assign contested = icache_data_req_i && dcache_data_req_i && !full;
    assign push      = grant_i || grant_d;
    assign head      = fifo_q[rd_ptr_q[PtrW-1:0]];
    assign pop       = !empty && (head.cnt == '0);

    assign icache_data_ack_o = grant_i;
    assign dcache_data_ack_o = grant_d;
    assign busy_o            = !empty;
    assign icache_rtrn_vld_o = pop && !head.side;
    assign dcache_rtrn_vld_o = pop && head.side;
    assign icache_rtrn_o     = icache_rtrn_vld_o ? head.irtrn : '0;
    assign dcache_rtrn_o     = dcache_rtrn_vld_o ? head.drtrn : '0;

    assign i_idx  = icache_data_i.paddr[AddrBits+2:3];
    assign d_idx  = dcache_data_i.paddr[AddrBits+2:3];
    assign i_base = i_idx & ~AddrBits'(IWords - 1);
    assign d_base = d_idx & ~AddrBits'(DWords - 1);
    assign d_word = mem_q[d_idx];

`ifdef WT_MEM_RSP_RANDOM_LAT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign load_cnt = CntW'(Latency - 1) + CntW'(lfsr_q[1:0]);
`else
    assign load_cnt = CntW'(Latency - 1);
`endif

    // Store merge and AMO result against the pre-accept word
    always_comb begin
        case (dcache_data_i.size[1:0])
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        be = lanes << dcache_data_i.paddr[2:0];
        for (int b = 0; b < 8; b++)
            st_word[b*8 +: 8] = be[b] ? dcache_data_i.data[b*8 +: 8] : d_word[b*8 +: 8];
        case (dcache_data_i.amo_op)
            AMO_SWAP: amo_word = dcache_data_i.data;
            AMO_ADD:  amo_word = (dcache_data_i.size[1:0] == 2'd2)
                                 ? {d_word[63:32], d_word[31:0] + dcache_data_i.data[31:0]}
                                 : d_word + dcache_data_i.data;
            default:  amo_word = d_word;
        endcase
    end

    // Precompute the return payload and array update for the granted request
    always_comb begin
        new_e     = '0;
        mem_we    = 1'b0;
        mem_wdata = st_word;
        new_e.cnt = load_cnt;
        if (grant_i) begin
            new_e.irtrn.rtype = ICACHE_IFILL_ACK;
            new_e.irtrn.tid   = icache_data_i.tid;
            for (int w = 0; w < int'(IWords); w++)
                new_e.irtrn.data[w*64 +: 64] = mem_q[i_base + AddrBits'(w)];
        end else if (grant_d) begin
            new_e.side      = 1'b1;
            new_e.drtrn.tid = dcache_data_i.tid;
            case (dcache_data_i.rtype)
                DCACHE_STORE_REQ: begin
                    new_e.drtrn.rtype = DCACHE_STORE_ACK;
                    mem_we            = 1'b1;
                end
                DCACHE_ATOMIC_REQ: begin
                    new_e.drtrn.rtype      = DCACHE_ATOMIC_ACK;
                    new_e.drtrn.data[63:0] = d_word;
                    mem_wdata              = amo_word;
                    mem_we                 = (dcache_data_i.amo_op == AMO_SWAP) ||
                                             (dcache_data_i.amo_op == AMO_ADD);
                end
                default: begin
                    new_e.drtrn.rtype = DCACHE_LOAD_ACK;
                    for (int w = 0; w < int'(DWords); w++)
                        new_e.drtrn.data[w*64 +: 64] = dcache_data_i.nc ? d_word
                                                     : mem_q[d_base + AddrBits'(w)];
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[d_idx] <= mem_wdata;
    end

    // Entry payloads are not reset; the pointers alone define validity
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(Depth); k++)
            if (fifo_q[k].cnt != '0) fifo_q[k].cnt <= fifo_q[k].cnt - CntW'(1);
        if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= new_e;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            if (push)      wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop)       rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            if (contested) rr_q     <= ~rr_q;
        end
    end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Scoreboard bench for wt_mem_responder: drivers push expected returns at ack, a monitor pops on return.
module tb_wt_mem_responder;
    import wt_cache_pkg::*;

    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_data_req_i, icache_data_ack_o, icache_rtrn_vld_o;
    icache_req_t  icache_data_i;
    icache_rtrn_t icache_rtrn_o;
    logic         dcache_data_req_i, dcache_data_ack_o, dcache_rtrn_vld_o;
    dcache_req_t  dcache_data_i;
    dcache_rtrn_t dcache_rtrn_o;
    logic         busy_o;

    wt_mem_responder #(.AddrBits(12), .Latency(LAT), .Depth(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .icache_data_req_i (icache_data_req_i),
        .icache_data_ack_o (icache_data_ack_o),
        .icache_data_i     (icache_data_i),
        .icache_rtrn_vld_o (icache_rtrn_vld_o),
        .icache_rtrn_o     (icache_rtrn_o),
        .dcache_data_req_i (dcache_data_req_i),
        .dcache_data_ack_o (dcache_data_ack_o),
        .dcache_data_i     (dcache_data_i),
        .dcache_rtrn_vld_o (dcache_rtrn_vld_o),
        .dcache_rtrn_o     (dcache_rtrn_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         side;
        logic [1:0]   rtype;
        logic [127:0] data;
        logic [2:0]   tid;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   ack_log[$];
    int   ack_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   vld_seen = 0;

    localparam logic [63:0] W0  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] W1  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] W0M = 64'h1111_2222_AB33_4444;
    localparam logic [63:0] W1M = 64'h5555_CAFE_7777_8888;
    localparam logic [63:0] DB  = 64'hDEAD_BEEF_0123_4567;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Return monitor: every valid pulse must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (icache_rtrn_vld_o || dcache_rtrn_vld_o)) begin
            vld_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rtrn: got i=%0b d=%0b expected no return", icache_rtrn_vld_o, dcache_rtrn_vld_o);
            end else begin
                e = sb.pop_front();
                chk("rtrn_side", 256'({icache_rtrn_vld_o, dcache_rtrn_vld_o}), e.side ? 256'(2'b01) : 256'(2'b10));
                if (e.side) begin
                    chk("d_rtype", 256'(dcache_rtrn_o.rtype), 256'(e.rtype));
                    chk("d_data",  256'(dcache_rtrn_o.data),  256'(e.data));
                    chk("d_tid",   256'(dcache_rtrn_o.tid),   256'(e.tid));
                    chk("d_inv",   256'(dcache_rtrn_o.inv),   256'(0));
                end else begin
                    chk("i_rtype", 256'(icache_rtrn_o.rtype), 256'(e.rtype));
                    chk("i_data",  256'(icache_rtrn_o.data),  256'(e.data));
                    chk("i_tid",   256'(icache_rtrn_o.tid),   256'(e.tid));
                    chk("i_inv",   256'(icache_rtrn_o.inv),   256'(0));
                end
`ifdef WT_MEM_RSP_RANDOM_LAT_EN
                chk("rtrn_lat_min", 256'(cyc - e.acc >= int'(LAT)), 256'(1));
`else
                chk("rtrn_lat", 256'(cyc - e.acc), 256'(LAT));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (icache_data_ack_o && dcache_data_ack_o)
                chk("dual_ack", 256'({icache_data_ack_o, dcache_data_ack_o}), 256'(2'b10));
            if (icache_data_ack_o) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
            if (dcache_data_ack_o) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
        end
    end

    task automatic send_i(input logic [63:0] paddr, input logic [1:0] tid, input logic [127:0] exp);
        exp_t e;
        bit   got = 0;
        icache_data_i       = '0;
        icache_data_i.rtype = ICACHE_IFILL_REQ;
        icache_data_i.paddr = paddr;
        icache_data_i.tid   = tid;
        icache_data_req_i   = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = icache_data_ack_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL i_ack_timeout: got no ack expected ack within 100 cycles");
        end else begin
            e.side  = 1'b0;
            e.rtype = 2'(ICACHE_IFILL_ACK);
            e.data  = exp;
            e.tid   = 3'(tid);
            e.acc   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        icache_data_req_i = 1'b0;
    endtask

    task automatic send_d(input dcache_out_t rt, input logic [2:0] size, input logic [63:0] paddr,
                          input logic [63:0] data, input amo_t op, input logic nc, input logic [2:0] tid,
                          input dcache_in_t ert, input logic [127:0] exp);
        exp_t e;
        bit   got = 0;
        dcache_data_i        = '0;
        dcache_data_i.rtype  = rt;
        dcache_data_i.size   = size;
        dcache_data_i.paddr  = paddr;
        dcache_data_i.data   = data;
        dcache_data_i.amo_op = op;
        dcache_data_i.nc     = nc;
        dcache_data_i.tid    = tid;
        dcache_data_req_i    = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = dcache_data_ack_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL d_ack_timeout: got no ack expected ack within 100 cycles");
        end else begin
            e.side  = 1'b1;
            e.rtype = 2'(ert);
            e.data  = exp;
            e.tid   = tid;
            e.acc   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        dcache_data_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            idle = !busy_o && (sb.size() == 0);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy_o, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        icache_data_req_i = 1'b0;
        dcache_data_req_i = 1'b0;
        icache_data_i     = '0;
        dcache_data_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  256'(busy_o), 256'(0));
        chk("rst_ivld",  256'(icache_rtrn_vld_o), 256'(0));
        chk("rst_dvld",  256'(dcache_rtrn_vld_o), 256'(0));
        chk("rst_iack",  256'(icache_data_ack_o), 256'(0));
        chk("rst_dack",  256'(dcache_data_ack_o), 256'(0));
        chk("rst_irtrn", 256'(icache_rtrn_o), 256'(0));
        chk("rst_drtrn", 256'(dcache_rtrn_o), 256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Preload a line, then fill it from both sides
        send_d(DCACHE_STORE_REQ, 3'd3, 64'h100, W0, AMO_NONE, 1'b0, 3'd1, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_STORE_REQ, 3'd3, 64'h108, W1, AMO_NONE, 1'b0, 3'd2, DCACHE_STORE_ACK, 128'h0);
        wait_idle();
        send_i(64'h100, 2'd2, {W1, W0});
        wait_idle();
        send_i(64'h108, 2'd1, {W1, W0});
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h108, 64'h0, AMO_NONE, 1'b0, 3'd5, DCACHE_LOAD_ACK, {W1, W0});
        wait_idle();

        // Store followed next cycle by a load of the same word
        send_d(DCACHE_STORE_REQ, 3'd3, 64'h40, DB, AMO_NONE, 1'b0, 3'd1, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h40, 64'h0, AMO_NONE, 1'b1, 3'd2, DCACHE_LOAD_ACK, {DB, DB});

        // Sub-word stores
        send_d(DCACHE_STORE_REQ, 3'd0, 64'h103, 64'h0000_0000_AB00_0000, AMO_NONE, 1'b0, 3'd3, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_STORE_REQ, 3'd1, 64'h10C, 64'h0000_CAFE_0000_0000, AMO_NONE, 1'b0, 3'd4, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h100, 64'h0, AMO_NONE, 1'b0, 3'd6, DCACHE_LOAD_ACK, {W1M, W0M});
        wait_idle();

        // Atomics
        send_d(DCACHE_STORE_REQ, 3'd3, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, AMO_NONE, 1'b0, 3'd0, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_ATOMIC_REQ, 3'd3, 64'h200, 64'h1, AMO_ADD, 1'b0, 3'd1, DCACHE_ATOMIC_ACK, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h200, 64'h0, AMO_NONE, 1'b1, 3'd2, DCACHE_LOAD_ACK, 128'h0);
        send_d(DCACHE_ATOMIC_REQ, 3'd3, 64'h200, 64'h1234, AMO_SWAP, 1'b0, 3'd3, DCACHE_ATOMIC_ACK, 128'h0);
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h200, 64'h0, AMO_NONE, 1'b1, 3'd4, DCACHE_LOAD_ACK, {64'h1234, 64'h1234});
        wait_idle();
        send_d(DCACHE_STORE_REQ, 3'd3, 64'h208, 64'h0000_0001_FFFF_FFFF, AMO_NONE, 1'b0, 3'd5, DCACHE_STORE_ACK, 128'h0);
        send_d(DCACHE_ATOMIC_REQ, 3'd2, 64'h208, 64'h1, AMO_ADD, 1'b0, 3'd6, DCACHE_ATOMIC_ACK, {64'h0, 64'h0000_0001_FFFF_FFFF});
        send_d(DCACHE_ATOMIC_REQ, 3'd3, 64'h208, 64'h0, AMO_AND, 1'b0, 3'd7, DCACHE_ATOMIC_ACK, {64'h0, 64'h0000_0001_0000_0000});
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h208, 64'h0, AMO_NONE, 1'b1, 3'd0, DCACHE_LOAD_ACK, {2{64'h0000_0001_0000_0000}});
        wait_idle();

        // Both sides requesting continuously: grants alternate starting with I$
        ack_log.delete();
        fork
            begin
                send_i(64'h100, 2'd0, {W1M, W0M});
                send_i(64'h108, 2'd1, {W1M, W0M});
                send_i(64'h100, 2'd2, {W1M, W0M});
            end
            begin
                send_d(DCACHE_LOAD_REQ, 3'd3, 64'h40, 64'h0, AMO_NONE, 1'b1, 3'd1, DCACHE_LOAD_ACK, {DB, DB});
                send_d(DCACHE_LOAD_REQ, 3'd3, 64'h200, 64'h0, AMO_NONE, 1'b1, 3'd2, DCACHE_LOAD_ACK, {64'h1234, 64'h1234});
                send_d(DCACHE_LOAD_REQ, 3'd3, 64'h100, 64'h0, AMO_NONE, 1'b0, 3'd3, DCACHE_LOAD_ACK, {W1M, W0M});
            end
        join
        chk("rr_count", 256'(ack_log.size()), 256'(6));
        for (int k = 0; k < 6 && k < ack_log.size(); k++)
            chk($sformatf("rr_order_%0d", k), 256'(ack_log[k]), 256'(k % 2));
        wait_idle();

        // FIFO full: four back-to-back acks, one stalled cycle, then ack again
        ack_cyc.delete();
        for (int k = 0; k < 5; k++) send_i(64'h100, 2'(k), {W1M, W0M});
`ifndef WT_MEM_RSP_RANDOM_LAT_EN
        chk("full_count", 256'(ack_cyc.size()), 256'(5));
        if (ack_cyc.size() == 5) begin
            for (int k = 1; k < 4; k++)
                chk($sformatf("full_gap_%0d", k), 256'(ack_cyc[k] - ack_cyc[0]), 256'(k));
            chk("full_stall", 256'(ack_cyc[4] - ack_cyc[3]), 256'(2));
        end
`endif
        wait_idle();

        // Reset with three pending returns
        for (int k = 0; k < 3; k++) send_i(64'h100, 2'(k), {W1M, W0M});
        chk("pre_rst_busy", 256'(busy_o), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 256'(busy_o), 256'(0));
        chk("mid_rst_ivld", 256'(icache_rtrn_vld_o), 256'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        vld_seen = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_rtrn", 256'(vld_seen), 256'(0));

        // Array survives reset
        send_d(DCACHE_LOAD_REQ, 3'd3, 64'h40, 64'h0, AMO_NONE, 1'b1, 3'd3, DCACHE_LOAD_ACK, {DB, DB});
        wait_idle();
        chk("sb_drain", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
